// File: rtl/eth_framer_pkg.sv
// Shared definitions for the Ethernet TX framer: header layout, FSM states
// and the header builder.
package eth_framer_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'hB1AD;
    localparam int SEQ_W   = 8;
    localparam int LEN_W   = 8;
    localparam int LEN_OFF = 0;
    localparam int SEQ_OFF = LEN_OFF + LEN_W;
    localparam int MAG_OFF = SEQ_OFF + SEQ_W;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} fsm_state_t;

    function automatic logic [31:0] make_header(input logic [SEQ_W-1:0] seq,
                                                input logic [LEN_W-1:0] len);
        logic [31:0] h;
        h = '0;
        h[MAG_OFF +: 16]    = HDR_MAGIC;
        h[SEQ_OFF +: SEQ_W] = seq;
        h[LEN_OFF +: LEN_W] = len;
        return h;
    endfunction

endpackage

// File: rtl/stream_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; rd_data always shows the head entry.
module stream_fifo_fwft #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign do_rd   = rd_en && (level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Buffers an input word stream and emits header-prefixed frames, flushing a
// short frame when the input stays below a full payload for TIMEOUT cycles.
module eth_tx_framer
    import eth_framer_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int FIFO_DEPTH    = 64,
    parameter int PAYLOAD_WORDS = 32,
    parameter int TIMEOUT       = 1024
) (
    input  logic                        CLK,
    input  logic                        MIB_MASTER_RESET,
    input  logic [DATA_W-1:0]           t0_data,
    input  logic                        t0_valid,
    output logic                        t0_ready,
    output logic [DATA_W-1:0]           i0_data,
    output logic                        i0_valid,
    input  logic                        i0_ready,
    output logic                        i0_last,
    output logic [15:0]                 frame_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(PAYLOAD_WORDS);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);

    fsm_state_t        state;
    logic [SEQ_W-1:0]  seq;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  remaining;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              wr_en;
    logic              rd_en;

    assign t0_ready = !fifo_full;
    assign wr_en    = t0_valid && t0_ready;
    assign rd_en    = (state == PAYLOAD) && i0_valid && i0_ready;
    assign i0_data  = (state == PAYLOAD) ? fifo_head : hdr_q;

    stream_fifo_fwft #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (MIB_MASTER_RESET),
        .wr_en   (wr_en),
        .wr_data (t0_data),
        .rd_en   (rd_en),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    always_ff @(posedge CLK) begin
        if (MIB_MASTER_RESET) begin
            state       <= IDLE;
            seq         <= '0;
            len         <= '0;
            remaining   <= '0;
            timer       <= '0;
            hdr_q       <= '0;
            frame_count <= '0;
            i0_valid    <= 1'b0;
            i0_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Full frame has priority over a timeout flush in the same cycle.
                    if (fifo_level >= FULL_LVL) begin
                        len      <= LEN_W'(PAYLOAD_WORDS);
                        hdr_q    <= make_header(seq, LEN_W'(PAYLOAD_WORDS));
                        i0_valid <= 1'b1;
                        timer    <= '0;
                        state    <= HEADER;
                    end else if (fifo_level != '0 && timer == TMO_MAX) begin
                        len      <= LEN_W'(fifo_level);
                        hdr_q    <= make_header(seq, LEN_W'(fifo_level));
                        i0_valid <= 1'b1;
                        timer    <= '0;
                        state    <= HEADER;
                    end else if (fifo_level == '0) begin
                        timer <= '0;
                    end else if (timer != TMO_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                HEADER: begin
                    if (i0_ready) begin
                        remaining <= len;
                        i0_last   <= (len == LEN_W'(1));
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (i0_ready) begin
                        if (remaining == LEN_W'(1)) begin
                            i0_valid    <= 1'b0;
                            i0_last     <= 1'b0;
                            frame_count <= frame_count + 1'b1;
                            seq         <= seq + 1'b1;
                            state       <= IDLE;
                        end else begin
                            remaining <= remaining - 1'b1;
                            i0_last   <= (remaining == LEN_W'(2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: reset, full frames, timeout flush,
// backpressure, full FIFO, sequence wrap and reset mid-frame.
module tb_eth_tx_framer;

    logic        CLK = 1'b0;
    logic        MIB_MASTER_RESET = 1'b1;
    logic [31:0] t0_data = '0;
    logic        t0_valid = 1'b0;
    logic        t0_ready;
    logic [31:0] i0_data;
    logic        i0_valid;
    logic        i0_ready = 1'b0;
    logic        i0_last;
    logic [15:0] frame_count;
    logic [6:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    eth_tx_framer #(
        .DATA_W(32), .FIFO_DEPTH(64), .PAYLOAD_WORDS(32), .TIMEOUT(64)
    ) dut (
        .CLK(CLK), .MIB_MASTER_RESET(MIB_MASTER_RESET),
        .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready),
        .i0_data(i0_data), .i0_valid(i0_valid), .i0_ready(i0_ready),
        .i0_last(i0_last), .frame_count(frame_count), .fifo_level(fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        MIB_MASTER_RESET = 1'b1;
        t0_valid = 1'b0;
        i0_ready = 1'b0;
        repeat (4) @(posedge CLK);
        #1 MIB_MASTER_RESET = 1'b0;
    endtask

    task automatic push(input logic [31:0] base, input int n);
        int  i = 0;
        int  guard = 0;
        logic acc;
        while (i < n && guard < 20000) begin
            t0_valid = 1'b1;
            t0_data  = base + i;
            @(negedge CLK);
            acc = t0_ready;
            @(posedge CLK);
            #1;
            if (acc) i++;
            guard++;
        end
        t0_valid = 1'b0;
        if (i < n) chk("push_timeout", i, n);
    endtask

    task automatic recv(input logic [7:0] seq, input logic [7:0] len,
                        input logic [31:0] base, input bit rnd, output int hdr_cyc);
        int beat = 0;
        int cyc = 0;
        bit stall = 0;
        logic [31:0] sd;
        logic        sl;
        hdr_cyc = -1;
        while (beat <= int'(len) && cyc < 5000) begin
            i0_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge CLK);
            if (stall) begin
                chk("stall_valid", 32'(i0_valid), 1);
                chk("stall_data", i0_data, sd);
                chk("stall_last", 32'(i0_last), 32'(sl));
            end
            stall = 0;
            if (i0_valid) begin
                if (hdr_cyc < 0) hdr_cyc = cyc;
                if (i0_ready) begin
                    if (beat == 0) begin
                        chk("header", i0_data, {16'hB1AD, seq, len});
                        chk("header_last", 32'(i0_last), 0);
                    end else begin
                        chk("payload", i0_data, base + 32'(beat - 1));
                        chk("payload_last", 32'(i0_last), 32'(beat == int'(len)));
                    end
                    beat++;
                end else begin
                    stall = 1;
                    sd = i0_data;
                    sl = i0_last;
                end
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        i0_ready = 1'b1;
        if (beat <= int'(len)) chk("recv_timeout", beat, 32'(len) + 1);
        chk("gap_valid_low", 32'(i0_valid), 0);
    endtask

    initial begin
        int hc;
        int acc_n;
        int nb;
        int cyc;

        // Reset state
        do_reset();
        @(negedge CLK);
        chk("rst_i0_valid", 32'(i0_valid), 0);
        chk("rst_i0_last", 32'(i0_last), 0);
        chk("rst_i0_data", i0_data, 0);
        chk("rst_t0_ready", 32'(t0_ready), 1);
        chk("rst_frame_count", 32'(frame_count), 0);
        chk("rst_fifo_level", 32'(fifo_level), 0);
        @(posedge CLK); #1;

        // Full frame, words 0..31
        i0_ready = 1'b1;
        fork
            push(32'h0, 32);
            recv(8'h00, 8'h20, 32'h0, 0, hc);
        join
        chk("full_frame_count", 32'(frame_count), 1);
        chk("full_fifo_level", 32'(fifo_level), 0);

        // Timeout flush of 5 words
        push(32'hA0, 5);
        chk("tmo_fifo_level", 32'(fifo_level), 5);
        recv(8'h01, 8'h05, 32'hA0, 0, hc);
        chk("tmo_flush_delay", 32'(hc >= 59 && hc <= 65), 1);
        chk("tmo_frame_count", 32'(frame_count), 2);

        // Backpressure over 3 full frames
        do_reset();
        fork
            push(32'h100, 96);
            begin
                recv(8'h00, 8'h20, 32'h100, 1, hc);
                recv(8'h01, 8'h20, 32'h120, 1, hc);
                recv(8'h02, 8'h20, 32'h140, 1, hc);
            end
        join
        chk("bp_frame_count", 32'(frame_count), 3);

        // Full FIFO: offer 70 words while downstream is stalled
        do_reset();
        i0_ready = 1'b0;
        acc_n = 0;
        for (int k = 0; k < 70; k++) begin
            t0_valid = 1'b1;
            t0_data  = acc_n;
            @(negedge CLK);
            if (t0_ready) acc_n++;
            @(posedge CLK); #1;
        end
        t0_valid = 1'b0;
        chk("ff_accepted", acc_n, 64);
        chk("ff_t0_ready", 32'(t0_ready), 0);
        chk("ff_fifo_level", 32'(fifo_level), 64);
        fork
            push(32'd64, 6);
            begin
                recv(8'h00, 8'h20, 32'd0, 0, hc);
                recv(8'h01, 8'h20, 32'd32, 0, hc);
                recv(8'h02, 8'h06, 32'd64, 0, hc);
            end
        join
        chk("ff_frame_count", 32'(frame_count), 3);

        // Sequence wrap over 257 frames
        do_reset();
        i0_ready = 1'b1;
        for (int f = 0; f < 257; f++) begin
            fork
                push(32'(f) << 8, 32);
                recv(8'(f), 8'h20, 32'(f) << 8, 0, hc);
            join
        end
        chk("wrap_frame_count", 32'(frame_count), 257);

        // Reset after header + 10 payload beats
        push(32'h5000, 32);
        nb = 0;
        cyc = 0;
        while (nb < 11 && cyc < 500) begin
            @(negedge CLK);
            if (i0_valid && i0_ready) nb++;
            @(posedge CLK); #1;
            cyc++;
        end
        chk("mid_beats", nb, 11);
        MIB_MASTER_RESET = 1'b1;
        @(posedge CLK); #1;
        chk("mid_rst_valid", 32'(i0_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_count", 32'(frame_count), 0);
        MIB_MASTER_RESET = 1'b0;
        i0_ready = 1'b1;
        fork
            push(32'h6000, 32);
            recv(8'h00, 8'h20, 32'h6000, 0, hc);
        join
        chk("post_rst_count", 32'(frame_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
